// File: rtl/id_ctrl_stage.sv
// ID control decoder behind a 2-entry skid buffer (head + skid) with registered in_ready.
// Define HILO_INTERLOCK_EN to add the HI/LO busy counter that holds HI/LO users behind MULT/DIV.
module id_ctrl_stage #(
  parameter int unsigned DIV_CYCLES  = 33,
  parameter int unsigned MULT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [2:0]  mem_read_type,
  output logic        jump,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic        reg_dst,
  output logic        imm_sel,
  output logic        hilo_we,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        epc_sel,
  output logic        hilo_stall,
  output logic        hilo_busy
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_COP0    = 6'b010000;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_LHU     = 6'b100101;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_SH      = 6'b101001;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] F_SLL     = 6'b000000;
  localparam logic [5:0] F_SRL     = 6'b000010;
  localparam logic [5:0] F_SRA     = 6'b000011;
  localparam logic [5:0] F_JR      = 6'b001000;
  localparam logic [5:0] F_JALR    = 6'b001001;
  localparam logic [5:0] F_SYSCALL = 6'b001100;
  localparam logic [5:0] F_BREAK   = 6'b001101;
  localparam logic [5:0] F_MFHI    = 6'b010000;
  localparam logic [5:0] F_MTHI    = 6'b010001;
  localparam logic [5:0] F_MFLO    = 6'b010010;
  localparam logic [5:0] F_MTLO    = 6'b010011;
  localparam logic [5:0] F_MULT    = 6'b011000;
  localparam logic [5:0] F_MULTU   = 6'b011001;
  localparam logic [5:0] F_DIV     = 6'b011010;
  localparam logic [5:0] F_DIVU    = 6'b011011;
  localparam logic [5:0] F_ERET    = 6'b011000;

  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  typedef struct packed {
    logic [2:0]  mem_read_type;
    logic        jump;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        reg_dst;
    logic        imm_sel;
    logic        hilo_we;
    logic        reg_write;
    logic        mem_to_reg;
    logic        epc_sel;
    logic        hilo_dep;
    logic        is_div;
    logic        is_mult;
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  localparam entry_t ENTRY_RST = '{mem_read_type: 3'b111, reg_write: 1'b1,
                                   mem_to_reg: 1'b1, epc_sel: 1'b1, default: '0};

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

  state_e state_q, state_d;
  entry_t head_q, head_d, skid_q, skid_d, dec;
  logic   head_valid, accept, advance, stall;
  logic   load_head_in, load_head_skid, load_skid;

  logic [5:0] op, funct;
  logic [4:0] rt;
  assign op    = in_instr[31:26];
  assign funct = in_instr[5:0];
  assign rt    = in_instr[20:16];

  // Control decode of the incoming instruction
  always_comb begin
    dec       = ENTRY_RST;
    dec.instr = in_instr;
    dec.pc    = in_pc;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_SLL, F_SRL, F_SRA: dec.alu_src_a = 1'b1;
          F_JR: begin
            dec.jump      = 1'b1;
            dec.reg_write = 1'b0;
          end
          F_JALR: begin
            dec.jump      = 1'b1;
            dec.alu_src_a = 1'b1;
            dec.imm_sel   = 1'b1;
          end
          F_SYSCALL, F_BREAK: dec.reg_write = 1'b0;
          F_MFHI, F_MFLO: dec.hilo_dep = 1'b1;
          F_MTHI, F_MTLO: begin
            dec.hilo_we   = 1'b1;
            dec.reg_write = 1'b0;
            dec.hilo_dep  = 1'b1;
          end
          F_MULT, F_MULTU: begin
            dec.hilo_we   = 1'b1;
            dec.reg_write = 1'b0;
            dec.hilo_dep  = 1'b1;
            dec.is_mult   = 1'b1;
          end
          F_DIV, F_DIVU: begin
            dec.hilo_we   = 1'b1;
            dec.reg_write = 1'b0;
            dec.hilo_dep  = 1'b1;
            dec.is_div    = 1'b1;
          end
          default: ;
        endcase
      end
      OP_REGIMM: begin
        dec.imm_sel = 1'b1;
        if (rt == RT_BLTZAL || rt == RT_BGEZAL) dec.alu_src_b = 1'b1;
        else                                    dec.reg_write = 1'b0;
      end
      OP_J: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b0;
      end
      OP_JAL: begin
        dec.jump      = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.imm_sel   = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: dec.reg_write = 1'b0;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: dec.alu_src_b = 1'b1;
      OP_COP0: if (funct == F_ERET) dec.epc_sel = 1'b0;
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b0;
        dec.alu_src_b  = 1'b1;
        case (op)
          OP_LB:   dec.mem_read_type = 3'b100;
          OP_LBU:  dec.mem_read_type = 3'b000;
          OP_LH:   dec.mem_read_type = 3'b101;
          OP_LHU:  dec.mem_read_type = 3'b001;
          default: dec.mem_read_type = 3'b010;
        endcase
      end
      OP_SB, OP_SH, OP_SW: begin
        dec.mem_write = 1'b1;
        dec.reg_write = 1'b0;
        dec.alu_src_b = 1'b1;
        case (op)
          OP_SB:   dec.mem_read_type = 3'b000;
          OP_SH:   dec.mem_read_type = 3'b001;
          default: dec.mem_read_type = 3'b010;
        endcase
      end
      default: ;
    endcase
    dec.reg_dst = ~dec.alu_src_b & ~(op == OP_SPECIAL && funct == F_JALR);
  end

  // Buffer occupancy register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  // Occupancy next state; flush wins over any accept
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) state_d = S_ONE;
        S_ONE: begin
          if (advance && !accept)      state_d = S_EMPTY;
          else if (!advance && accept) state_d = S_FULL;
        end
        S_FULL:  if (advance) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Handshake and load-steering outputs
  always_comb begin
    head_valid     = (state_q != S_EMPTY);
    in_ready       = (state_q != S_FULL);
    out_valid      = head_valid && !stall;
    hilo_stall     = stall;
    accept         = in_valid && in_ready;
    advance        = out_valid && out_ready;
    load_head_in   = accept && ((state_q == S_EMPTY) || (state_q == S_ONE && advance));
    load_skid      = accept && (state_q == S_ONE) && !advance;
    load_head_skid = advance && (state_q == S_FULL);
  end

  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    if (load_head_in)   head_d = dec;
    if (load_head_skid) head_d = skid_q;
    if (load_skid)      skid_d = dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= ENTRY_RST;
      skid_q <= ENTRY_RST;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

`ifdef HILO_INTERLOCK_EN
  localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;

  assign stall     = head_valid && head_q.hilo_dep && (busy_cnt_q != '0);
  assign hilo_busy = (busy_cnt_q != '0);

  // Charge HI/LO busy time on MULT/DIV transfer, otherwise drain to zero
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (advance && head_q.is_div)       busy_cnt_d = CNT_W'(DIV_CYCLES);
    else if (advance && head_q.is_mult) busy_cnt_d = CNT_W'(MULT_CYCLES);
    else if (busy_cnt_q != '0)          busy_cnt_d = busy_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_cnt_q <= '0;
    else     busy_cnt_q <= busy_cnt_d;
  end
`else
  logic unused_hilo;
  assign stall       = 1'b0;
  assign hilo_busy   = 1'b0;
  assign unused_hilo = ^{head_q.hilo_dep, head_q.is_div, head_q.is_mult,
                         DIV_CYCLES[0], MULT_CYCLES[0]};
`endif

  assign out_instr     = head_q.instr;
  assign out_pc        = head_q.pc;
  assign mem_read_type = head_q.mem_read_type;
  assign jump          = head_q.jump;
  assign mem_read      = head_q.mem_read;
  assign mem_write     = head_q.mem_write;
  assign alu_src_a     = head_q.alu_src_a;
  assign alu_src_b     = head_q.alu_src_b;
  assign reg_dst       = head_q.reg_dst;
  assign imm_sel       = head_q.imm_sel;
  assign hilo_we       = head_q.hilo_we;
  assign reg_write     = head_q.reg_write;
  assign mem_to_reg    = head_q.mem_to_reg;
  assign epc_sel       = head_q.epc_sel;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed self-checking bench for id_ctrl_stage; interlock checks follow HILO_INTERLOCK_EN.
module tb_id_ctrl_stage;

  localparam int unsigned DIVC = 33;

  localparam logic [31:0] I_ADDIU  = 32'h2401_0005;
  localparam logic [31:0] I_LW     = 32'h8C02_0000;
  localparam logic [31:0] I_SW     = 32'hAC02_0004;
  localparam logic [31:0] I_ADDU   = 32'h0043_0821;
  localparam logic [31:0] I_DIV    = 32'h0022_001A;
  localparam logic [31:0] I_MFLO   = 32'h0000_1812;
  localparam logic [31:0] I_MFHI   = 32'h0000_1810;
  localparam logic [31:0] I_JALR   = 32'h0020_F809;
  localparam logic [31:0] I_ERET   = 32'h4200_0018;
  localparam logic [31:0] I_BLTZAL = 32'h0430_0004;
  localparam logic [31:0] I_BREAK  = 32'h0000_000D;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_instr, out_pc;
  logic [2:0]  mem_read_type;
  logic        jump, mem_read, mem_write, alu_src_a, alu_src_b, reg_dst, imm_sel, hilo_we;
  logic        reg_write, mem_to_reg, epc_sel, hilo_stall, hilo_busy;

  int checks   = 0;
  int failures = 0;

  id_ctrl_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .mem_read_type(mem_read_type),
    .jump(jump), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_dst(reg_dst),
    .imm_sel(imm_sel), .hilo_we(hilo_we), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .epc_sel(epc_sel),
    .hilo_stall(hilo_stall), .hilo_busy(hilo_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
  endtask

  initial begin
    int n;
    clk = 1'b0; rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mrt", 32'(mem_read_type), 32'd7);
    chk("rst_reg_write", 32'(reg_write), 32'd1);
    chk("rst_mem_to_reg", 32'(mem_to_reg), 32'd1);
    chk("rst_epc_sel", 32'(epc_sel), 32'd1);
    chk("rst_jump", 32'(jump), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_hilo_busy", 32'(hilo_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming at one per cycle
    out_ready = 1'b1;
    drive(1'b1, I_ADDIU, 32'h100);
    tick();
    chk("addiu_valid", 32'(out_valid), 32'd1);
    chk("addiu_instr", out_instr, I_ADDIU);
    chk("addiu_alu_src_b", 32'(alu_src_b), 32'd1);
    chk("addiu_reg_dst", 32'(reg_dst), 32'd0);
    drive(1'b1, I_LW, 32'h104);
    tick();
    chk("lw_valid", 32'(out_valid), 32'd1);
    chk("lw_pc", out_pc, 32'h104);
    chk("lw_mem_read", 32'(mem_read), 32'd1);
    chk("lw_mem_to_reg", 32'(mem_to_reg), 32'd0);
    chk("lw_mrt", 32'(mem_read_type), 32'd2);
    drive(1'b1, I_SW, 32'h108);
    tick();
    chk("sw_instr", out_instr, I_SW);
    chk("sw_mem_write", 32'(mem_write), 32'd1);
    chk("sw_reg_write", 32'(reg_write), 32'd0);
    chk("sw_mrt", 32'(mem_read_type), 32'd2);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("stream_drained", 32'(out_valid), 32'd0);

    // Backpressure: fill head and skid, then drain in order
    out_ready = 1'b0;
    drive(1'b1, I_ADDU, 32'h200);
    tick();
    chk("bp1_in_ready", 32'(in_ready), 32'd1);
    chk("bp1_head", out_instr, I_ADDU);
    drive(1'b1, I_LW, 32'h204);
    tick();
    chk("bp2_in_ready", 32'(in_ready), 32'd0);
    chk("bp2_head_pc", out_pc, 32'h200);
    drive(1'b1, I_SW, 32'h208);
    tick();
    chk("bp3_in_ready", 32'(in_ready), 32'd0);
    chk("bp3_head_pc", out_pc, 32'h200);
    chk("bp3_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("bp4_head_pc", out_pc, 32'h204);
    chk("bp4_mem_read", 32'(mem_read), 32'd1);
    chk("bp4_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp5_empty", 32'(out_valid), 32'd0);

    // Decode corners
    drive(1'b1, I_JALR, 32'h300);
    tick();
    chk("jalr_reg_dst", 32'(reg_dst), 32'd0);
    chk("jalr_alu_src_a", 32'(alu_src_a), 32'd1);
    chk("jalr_imm_sel", 32'(imm_sel), 32'd1);
    chk("jalr_jump", 32'(jump), 32'd1);
    drive(1'b1, I_ERET, 32'h304);
    tick();
    chk("eret_epc_sel", 32'(epc_sel), 32'd0);
    drive(1'b1, I_BLTZAL, 32'h308);
    tick();
    chk("bltzal_reg_write", 32'(reg_write), 32'd1);
    chk("bltzal_alu_src_b", 32'(alu_src_b), 32'd1);
    chk("bltzal_epc_sel", 32'(epc_sel), 32'd1);
    drive(1'b1, I_BREAK, 32'h30C);
    tick();
    chk("break_reg_write", 32'(reg_write), 32'd0);
    chk("break_reg_dst", 32'(reg_dst), 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    tick();

    // DIV followed by MFLO
    drive(1'b1, I_DIV, 32'h400);
    tick();
    chk("div_valid", 32'(out_valid), 32'd1);
    chk("div_hilo_we", 32'(hilo_we), 32'd1);
    chk("div_reg_write", 32'(reg_write), 32'd0);
    drive(1'b1, I_MFLO, 32'h404);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("mflo_head", out_instr, I_MFLO);
`ifdef HILO_INTERLOCK_EN
    chk("mflo_stall", 32'(hilo_stall), 32'd1);
    chk("mflo_busy", 32'(hilo_busy), 32'd1);
    n = 0;
    while (!out_valid && n < 200) begin
      n++;
      tick();
    end
    chk("mflo_stall_cycles", 32'(n), 32'(DIVC));
    chk("mflo_released_stall", 32'(hilo_stall), 32'd0);
`else
    n = 0;
    chk("mflo_valid", 32'(out_valid), 32'd1);
    chk("mflo_no_stall", 32'(hilo_stall), 32'd0);
    chk("mflo_no_busy", 32'(hilo_busy), 32'd0);
`endif
    tick();
    chk("mflo_gone", 32'(out_valid), 32'd0);

    // Flush while FULL with a DIV in flight
    drive(1'b1, I_DIV, 32'h500);
    tick();
    drive(1'b1, I_MFHI, 32'h504);
    tick();
    out_ready = 1'b0;
    drive(1'b1, I_ADDU, 32'h508);
    tick();
    chk("fl_full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    drive(1'b1, I_LW, 32'h50C);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
`ifdef HILO_INTERLOCK_EN
    chk("fl_busy", 32'(hilo_busy), 32'd1);
`else
    chk("fl_busy", 32'(hilo_busy), 32'd0);
`endif

    // Reset mid-operation while FULL and busy
    out_ready = 1'b1;
    drive(1'b1, I_DIV, 32'h600);
    tick();
    drive(1'b1, I_LW, 32'h604);
    tick();
    out_ready = 1'b0;
    drive(1'b1, I_MFHI, 32'h608);
    tick();
    chk("prerst_full", 32'(in_ready), 32'd0);
    chk("prerst_mrt", 32'(mem_read_type), 32'd2);
    drive(1'b0, 32'h0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_mrt", 32'(mem_read_type), 32'd7);
    chk("arst_mem_to_reg", 32'(mem_to_reg), 32'd1);
    chk("arst_out_pc", out_pc, 32'h0);
    chk("arst_busy", 32'(hilo_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, I_MFHI, 32'h700);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("postrst_mfhi_valid", 32'(out_valid), 32'd1);
    chk("postrst_mfhi_stall", 32'(hilo_stall), 32'd0);
    chk("postrst_mfhi_instr", out_instr, I_MFHI);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
